// File: rtl/multu.sv
// 32x32 unsigned multiplier with a single output register.
// Product is formed from 32 shifted partial products reduced by a 5-level
// binary adder tree; everything between a/b and z is combinational, so the
// result appears on z one clock after the operands are captured.
module multu (
  input  logic        clk,
  input  logic        reset,   // active-low, asynchronous
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] z
);

  localparam int unsigned OpW   = 32;
  localparam int unsigned ProdW = 64;

  // Partial products and the adder tree levels (16 -> 8 -> 4 -> 2 -> 1).
  logic [ProdW-1:0] pp     [OpW];
  logic [ProdW-1:0] lvl1   [16];
  logic [ProdW-1:0] lvl2   [8];
  logic [ProdW-1:0] lvl3   [4];
  logic [ProdW-1:0] lvl4   [2];
  logic [ProdW-1:0] prod_d;
  logic [ProdW-1:0] z_q;

  // Zero-extended multiplicand so shifts never lose upper bits.
  logic [ProdW-1:0] a_ext;
  assign a_ext = {{(ProdW - OpW){1'b0}}, a};

  // Gate the shifted multiplicand with each multiplier bit.
  always_comb begin
    for (int i = 0; i < OpW; i++) begin
      pp[i] = b[i] ? (a_ext << i) : '0;
    end
  end

  // Tree level 1: 32 partial products into 16 sums.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      lvl1[i] = pp[2*i] + pp[2*i+1];
    end
  end

  // Tree level 2: 16 into 8.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    end
  end

  // Tree level 3: 8 into 4.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl3[i] = lvl2[2*i] + lvl2[2*i+1];
    end
  end

  // Tree level 4: 4 into 2.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lvl4[i] = lvl3[2*i] + lvl3[2*i+1];
    end
  end

  // Final level: full 64-bit product, no carry dropped.
  always_comb begin
    prod_d = lvl4[0] + lvl4[1];
  end

  // Output register; reset clears any in-flight product immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_q <= '0;
    end else begin
      z_q <= prod_d;
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_multu.sv
// Self-checking bench for multu: directed corner cases, async reset checks and
// a randomized regression compared against a plain arithmetic product model.
module tb_multu;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic [63:0] z;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Product expected on z after the next rising edge.
  bit          pend     = 1'b0;
  logic [63:0] pend_exp = '0;
  string       pend_tag = "";

  multu dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .z    (z)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = {32'b0, x};
    ye = {32'b0, y};
    return xe * ye;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // At each falling edge: check the product captured on the previous rising
  // edge, then present the next operand pair.
  task automatic step(input string tag, input logic [31:0] na, input logic [31:0] nb,
                      input logic [63:0] exp);
    @(negedge clk);
    if (pend) check(pend_tag, z, pend_exp);
    a        = na;
    b        = nb;
    pend_exp = exp;
    pend_tag = tag;
    pend     = 1'b1;
  endtask

  task automatic step_rand(input string tag, input logic [31:0] na, input logic [31:0] nb);
    step(tag, na, nb, ref_prod(na, nb));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset asserted with random operands: z must stay 0 across clock edges.
    a = $urandom;
    b = $urandom;
    #1 reset = 1'b0;
    #1 check("rst_async", z, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold", z, 64'h0);
      a = $urandom;
      b = $urandom;
    end
    @(negedge clk);
    reset = 1'b1;
    #1 check("rst_release", z, 64'h0);
    // First edge after release captures the current random operands.
    pend_exp = ref_prod(a, b);
    pend_tag = "rst_first_capture";
    pend     = 1'b1;

    // Maximum operands.
    step("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);

    // Zeros and small values, back-to-back.
    step("zero_zero", 32'h0,  32'h0,  64'h0);
    step("b_zero",    32'hB3, 32'h0,  64'h0);
    step("ff_ff",     32'hFF, 32'hFF, 64'hFE01);

    // Commutativity and mixed operands, no bubbles.
    step("mix_80_aa", 32'h80, 32'hAA, 64'h5500);
    step("mix_aa_80", 32'hAA, 32'h80, 64'h5500);
    step("mix_2d_d0", 32'h2D, 32'hD0, 64'h2490);
    step("mix_47_0e", 32'h47, 32'h0E, 64'h3E2);
    step("a_zero",    32'h0,  32'hDEAD_BEEF, 64'h0);

    // Reset mid-stream: product is captured, then cleared without a clock edge.
    step("mid_cap", 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080);
    @(posedge clk);
    #2 check(pend_tag, z, pend_exp);
    pend = 1'b0;
    #1 reset = 1'b0;
    #1 check("mid_async_clear", z, 64'h0);
    a = 32'h0001_0000;
    b = 32'h0001_0000;
    @(posedge clk);
    #1 check("mid_hold", z, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("mid_release", z, 64'h0);
    pend_exp = 64'h1_0000_0000;
    pend_tag = "mid_first_capture";
    pend     = 1'b1;

    // Walking ones on each operand against random partners.
    for (int i = 0; i < 32; i++) begin
      ra = 32'h1 << i;
      rb = $urandom;
      step_rand("walk_a", ra, rb);
    end
    for (int i = 0; i < 32; i++) begin
      ra = $urandom;
      rb = 32'h1 << i;
      step_rand("walk_b", ra, rb);
    end
    for (int i = 0; i < 32; i++) begin
      ra = 32'hFFFF_FFFF;
      rb = 32'h1 << i;
      step_rand("walk_b_max_a", ra, rb);
    end

    // Random regression, one pair per cycle.
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      // Occasionally force all-ones or zero operands.
      case ($urandom_range(0, 15))
        0: ra = 32'hFFFF_FFFF;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h0;
        3: rb = 32'h0;
        default: ;
      endcase
      step_rand("random", ra, rb);
    end

    // Flush the last pending product.
    @(negedge clk);
    if (pend) check(pend_tag, z, pend_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time limit so the bench can never hang.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
